// File: rtl/timer_ctrl.sv
// Alarm/interval controller for a 16-bit up-counting timer: paces the timer
// enable through a prescaler and raises alarms on target match (one-shot or periodic).
module timer_ctrl #(
  parameter int unsigned PRESC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        periodic,
  input  logic [15:0] target,
  input  logic [15:0] tmr_value,
  output logic        tmr_en,
  output logic        tmr_rst,
  output logic        alarm,
  output logic [7:0]  alarm_cnt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] target_q;
  logic        periodic_q;
  logic        alarm_q;
  logic        err_q;
  logic [7:0]  alarm_cnt_q;

  logic match;
  logic can_start;
  logic accept;
  logic reject;
  logic hit;

  assign match     = (state_q == RUN) && (tmr_value == target_q);
  // stop outranks start in DONE, so a start there only counts without stop
  assign can_start = (state_q == IDLE) || ((state_q == DONE) && !stop);
  assign accept    = can_start && start && (target != 16'd0);
  assign reject    = can_start && start && (target == 16'd0);
  assign hit       = match && !stop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = CLEAR;
      CLEAR: state_d = stop ? IDLE : RUN;
      RUN: begin
        if (stop)       state_d = IDLE;
        else if (match) state_d = periodic_q ? CLEAR : DONE;
      end
      DONE: begin
        if (stop)        state_d = IDLE;
        else if (accept) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_en  = (state_q == RUN) && (presc_q == PRESC_LAST) && !match && !stop;
    tmr_rst = rst || (state_q == CLEAR);
    busy    = (state_q == CLEAR) || (state_q == RUN);
    done    = (state_q == DONE);
  end

  always_comb begin
    presc_d = 16'd0;
    if ((state_q == RUN) && !match && !stop) begin
      presc_d = (presc_q == PRESC_LAST) ? 16'd0 : presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= 16'd0;
      target_q    <= 16'd0;
      periodic_q  <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
      alarm_q <= hit;
      err_q   <= reject;
      if (accept) begin
        target_q    <= target;
        periodic_q  <= periodic;
        alarm_cnt_q <= 8'd0;
      end else if (hit) begin
        alarm_cnt_q <= alarm_cnt_q + 8'd1;
      end
    end
  end

  assign alarm     = alarm_q;
  assign err       = err_q;
  assign alarm_cnt = alarm_cnt_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: two instances (PRESC 4 and 1) share stimulus, each drives
// its own timer and is checked every cycle against a run-offset reference model.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        periodic;
  logic [15:0] target;

  logic        tmr_en [2];
  logic        tmr_rst[2];
  logic        alarm  [2];
  logic [7:0]  alarm_cnt[2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];
  logic [15:0] tv     [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.PRESC(4)) u_p4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .target(target), .tmr_value(tv[0]), .tmr_en(tmr_en[0]), .tmr_rst(tmr_rst[0]),
    .alarm(alarm[0]), .alarm_cnt(alarm_cnt[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0])
  );

  timer_ctrl #(.PRESC(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .target(target), .tmr_value(tv[1]), .tmr_en(tmr_en[1]), .tmr_rst(tmr_rst[1]),
    .alarm(alarm[1]), .alarm_cnt(alarm_cnt[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1])
  );

  // Timers owned by the DUTs through their enable and clear outputs
  always @(posedge clk) begin
    if (tmr_rst[0])     tv[0] <= 16'd0;
    else if (tmr_en[0]) tv[0] <= tv[0] + 16'd1;
  end
  always @(posedge clk) begin
    if (tmr_rst[1])     tv[1] <= 16'd0;
    else if (tmr_en[1]) tv[1] <= tv[1] + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 active (clear+run), 2 done. t counts cycles since the
  // CLEAR cycle of the current period; the match cycle is t == target*PRESC + 1.
  typedef struct {
    int mode;
    int t;
    int tgt;
    bit per;
    int cnt;
    bit err_p;
    bit alarm_p;
  } mdl_t;

  mdl_t m [2];
  int   pr[2] = '{4, 1};

  bit   rec = 1'b0;
  int   base = 0;
  int   alarm_at[$];

  function automatic bit m_match(int i);
    return (m[i].mode == 1) && (m[i].t == m[i].tgt * pr[i] + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{mode: 0, t: 0, tgt: 0, per: 1'b0, cnt: 0, err_p: 1'b0, alarm_p: 1'b0};
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit exp_en;
      string p;
      p = $sformatf("p%0d", pr[i]);
      exp_en = (m[i].mode == 1) && (m[i].t >= 1) && !m_match(i) &&
               (((m[i].t - 1) % pr[i]) == pr[i] - 1) && !stop;
      check({p, "_tmr_en"},  32'(tmr_en[i]),  32'(exp_en));
      check({p, "_tmr_rst"}, 32'(tmr_rst[i]), 32'(rst || (m[i].mode == 1 && m[i].t == 0)));
      check({p, "_busy"},    32'(busy[i]),    32'(m[i].mode == 1));
      check({p, "_done"},    32'(done[i]),    32'(m[i].mode == 2));
      check({p, "_alarm"},   32'(alarm[i]),   32'(m[i].alarm_p));
      check({p, "_err"},     32'(err[i]),     32'(m[i].err_p));
      check({p, "_cnt"},     32'(alarm_cnt[i]), 32'(m[i].cnt));
      if (m[i].mode == 1 && m[i].t >= 1) check({p, "_tval"}, 32'(tv[i]), 32'((m[i].t - 1) / pr[i]));
      if (m[i].mode == 2)                check({p, "_tval_hold"}, 32'(tv[i]), 32'(m[i].tgt));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit mt;
      mt = m_match(i);
      m[i].err_p   = 1'b0;
      m[i].alarm_p = 1'b0;
      if (rst) begin
        m[i].mode = 0; m[i].t = 0; m[i].cnt = 0;
      end else if (m[i].mode == 1) begin
        if (stop) m[i].mode = 0;
        else if (mt) begin
          m[i].alarm_p = 1'b1;
          m[i].cnt = (m[i].cnt + 1) % 256;
          if (m[i].per) m[i].t = 0;
          else          m[i].mode = 2;
        end else m[i].t++;
      end else if (m[i].mode == 2 && stop) begin
        m[i].mode = 0;
      end else if (start) begin
        if (target != 16'd0) begin
          m[i].mode = 1; m[i].t = 0; m[i].tgt = int'(target);
          m[i].per = periodic; m[i].cnt = 0;
        end else m[i].err_p = 1'b1;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    if (rec && alarm[0]) alarm_at.push_back(cyc - base);
    check_all();
    model_step();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    cyc++;
  endtask

  task automatic begin_run(input logic [15:0] tg, input logic per);
    target = tg; periodic = per; start = 1'b1;
  endtask

  task automatic oneshot_scenario();
    begin_run(16'd3, 1'b0);
    base = cyc;
    repeat (16) run_cycle();
    check("os_done",     32'(done[0]),      32'd1);
    check("os_cnt",      32'(alarm_cnt[0]), 32'd1);
    check("os_tval",     32'(tv[0]),        32'd3);
    check("os_p1_done",  32'(done[1]),      32'd1);
    stop = 1'b1;
    run_cycle();
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; target = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run_cycle();
    rst = 1'b0;
    run_cycle();

    oneshot_scenario();

    // Periodic PRESC=4 target=3: alarms at 15, 29, 43 after the start cycle
    begin_run(16'd3, 1'b1);
    base = cyc; rec = 1'b1; alarm_at.delete();
    repeat (45) run_cycle();
    rec = 1'b0;
    check("per_n_alarms", 32'(alarm_at.size()), 32'd3);
    if (alarm_at.size() == 3) begin
      check("per_alarm0", 32'(alarm_at[0]), 32'd15);
      check("per_alarm1", 32'(alarm_at[1]), 32'd29);
      check("per_alarm2", 32'(alarm_at[2]), 32'd43);
    end
    check("per_cnt", 32'(alarm_cnt[0]), 32'd3);

    // Stop landing exactly on a match cycle of the PRESC=4 instance
    waited = 0;
    while (!m_match(0) && waited < 100) begin
      run_cycle();
      waited++;
    end
    check("stop_wait_in_budget", 32'(waited < 100), 32'd1);
    stop = 1'b1;
    run_cycle();
    check("stop_cnt_kept", 32'(alarm_cnt[0]), 32'd3);
    check("stop_idle",     32'(busy[0]),      32'd0);
    repeat (3) run_cycle();

    // PRESC=1 target=1 periodic: alarms every 3 cycles on the second instance
    begin_run(16'd1, 1'b1);
    repeat (14) run_cycle();
    stop = 1'b1;
    run_cycle();

    // Rejected start with zero target
    begin_run(16'd0, 1'b0);
    run_cycle();
    check("zero_err",  32'(err[0]),  32'd1);
    check("zero_busy", 32'(busy[0]), 32'd0);
    repeat (3) run_cycle();

    // Reset in the middle of a periodic run, then a fresh one-shot
    begin_run(16'd2, 1'b1);
    repeat (10) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    check("rst_busy", 32'(busy[0]),      32'd0);
    check("rst_cnt",  32'(alarm_cnt[0]), 32'd0);
    run_cycle();
    oneshot_scenario();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 399) == 0);
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 49) == 0);
      target   = 16'($urandom_range(0, 6));
      periodic = 1'($urandom_range(0, 1));
      run_cycle();
    end
    rst = 1'b0;
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
